dmem_access_ctrl: RTL

// Sequences and shares the single-ported word data memory between two requesters:

---
 rtl/dmem_access_ctrl_pkg.sv | 14 +
 rtl/dmem_access_ctrl_if.sv | 26 ++
 rtl/dmem_access_ctrl_lane_align.sv | 51 +++++
 rtl/dmem_access_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: funct3 codes,
// FSM states and requester identifiers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} dmem_state_e;
  typedef enum logic {PORT_C, PORT_D} port_e;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Requester port bundle (core LSU / debug-DMA) and the word-memory bundle.
// The controller uses the slave side of the port bundle and the master side of the memory bundle.
interface dmem_port_if #(parameter int AW = 9, parameter int DW = 32);
  logic          req;
  logic          we;
  logic [2:0]    funct3;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;

  modport master (output req, we, funct3, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, funct3, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

interface dmem_mem_if #(parameter int AW = 9, parameter int DW = 32);
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output addr, we, wdata, input rdata);
  modport slave  (input addr, we, wdata, output rdata);
endinterface

// File: rtl/dmem_access_ctrl_lane_align.sv
// Combinational lane logic: load byte/half extraction with sign/zero extension,
// sub-word store merge into the old word, and misaligned/illegal funct3 detection.
module dmem_lane_align
  import dmem_pkg::*;
#(parameter int DATA_W = 32)
(
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rword_i,
  output logic [DATA_W-1:0] ldata_o,
  output logic [DATA_W-1:0] mword_o,
  output logic              err_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        illegal, misalign;

  assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    ldata_o = rword_i;
    unique case (funct3_i)
      F3_B:    ldata_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_H:    ldata_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_BU:   ldata_o = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_HU:   ldata_o = {{(DATA_W-16){1'b0}}, half_sel};
      default: ldata_o = rword_i;
    endcase
  end

  // Untouched lanes keep the old word read back during the RMW.
  always_comb begin
    mword_o = rword_i;
    unique case (funct3_i)
      F3_B:    mword_o[{addr_lo_i, 3'b000} +: 8]     = wdata_i[7:0];
      F3_H:    mword_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: mword_o = wdata_i;
    endcase
  end

  assign illegal  = we_i ? (funct3_i > F3_W)
                         : !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign misalign = ((funct3_i == F3_H || funct3_i == F3_HU) && addr_lo_i[0]) ||
                    (funct3_i == F3_W && addr_lo_i != 2'b00);
  assign err_o    = illegal | misalign;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Shares one single-ported word memory between the core (C) and debug/DMA (D) ports:
// round-robin arbitration, one transaction in flight, RMW for sub-word stores.
module dmem_access_ctrl
  import dmem_pkg::*;
#(parameter int DM_ADDRESS = 9, parameter int DATA_W = 32)
(
  input  logic       clk,
  input  logic       reset,
  dmem_port_if.slave c_if,
  dmem_port_if.slave d_if,
  dmem_mem_if.master mem_if
);

  dmem_state_e             state_q;
  port_e                   port_q, last_gnt_q;
  logic                    we_q, err_q;
  logic [2:0]              f3_q;
  logic [DM_ADDRESS-1:0]   addr_q;
  logic [DATA_W-1:0]       wdata_q;

  logic                    tie, pick_d, grant;
  logic                    in_we;
  logic [2:0]              in_f3;
  logic [DM_ADDRESS-1:0]   in_addr;
  logic [DATA_W-1:0]       in_wdata;
  logic                    sel_we;
  logic [2:0]              sel_f3;
  logic [1:0]              sel_lo;
  logic [DATA_W-1:0]       ldata, mword;
  logic                    lane_err, resp, c_resp, d_resp;

  // D wins when it is alone, or on a tie when C was granted last.
  assign tie    = c_if.req & d_if.req;
  assign pick_d = d_if.req & (~c_if.req | (last_gnt_q == PORT_C));
  assign grant  = (state_q == IDLE) & (c_if.req | d_if.req) & ~reset;

  assign in_we    = pick_d ? d_if.we     : c_if.we;
  assign in_f3    = pick_d ? d_if.funct3 : c_if.funct3;
  assign in_addr  = pick_d ? d_if.addr   : c_if.addr;
  assign in_wdata = pick_d ? d_if.wdata  : c_if.wdata;

  // The error check must see the incoming request in IDLE; later it sees the latched one.
  assign sel_we = (state_q == IDLE) ? in_we       : we_q;
  assign sel_f3 = (state_q == IDLE) ? in_f3       : f3_q;
  assign sel_lo = (state_q == IDLE) ? in_addr[1:0] : addr_q[1:0];

  dmem_lane_align #(.DATA_W(DATA_W)) u_lane (
    .we_i      (sel_we),
    .funct3_i  (sel_f3),
    .addr_lo_i (sel_lo),
    .wdata_i   (wdata_q),
    .rword_i   (mem_if.rdata),
    .ldata_o   (ldata),
    .mword_o   (mword),
    .err_o     (lane_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      port_q     <= PORT_C;
      last_gnt_q <= PORT_D;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (grant) begin
          port_q  <= pick_d ? PORT_D : PORT_C;
          we_q    <= in_we;
          f3_q    <= in_f3;
          addr_q  <= in_addr;
          wdata_q <= in_wdata;
          err_q   <= lane_err;
          if (tie) last_gnt_q <= pick_d ? PORT_D : PORT_C;
          if (lane_err)                  state_q <= RESP;
          else if (in_we && in_f3 == F3_W) state_q <= WR;
          else                           state_q <= RD;
        end
        RD:   state_q <= we_q ? WR : RESP;
        WR:   state_q <= RESP;
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign c_if.gnt = grant & ~pick_d;
  assign d_if.gnt = grant &  pick_d;

  assign resp   = (state_q == RESP);
  assign c_resp = resp & (port_q == PORT_C);
  assign d_resp = resp & (port_q == PORT_D);

  assign c_if.rvalid = c_resp;
  assign d_if.rvalid = d_resp;
  assign c_if.err    = c_resp & err_q;
  assign d_if.err    = d_resp & err_q;
  assign c_if.rdata  = (c_resp & ~err_q & ~we_q) ? ldata : '0;
  assign d_if.rdata  = (d_resp & ~err_q & ~we_q) ? ldata : '0;

  // The memory's registered read port presents the old word during WR, so the merge uses it directly.
  assign mem_if.addr  = (state_q == RD || state_q == WR) ? {addr_q[DM_ADDRESS-1:2], 2'b00} : '0;
  assign mem_if.we    = (state_q == WR);
  assign mem_if.wdata = (state_q == WR) ? mword : '0;

endmodule
